instr_sequencer: RTL
====================

# instr_sequencer

Multi-cycle fetch/decode/execute sequencer for the 8-bit microprocessor. It owns the program counter and instruction register. It fetches 9-bit microinstructions over a request/acknowledge handshake with instruction memory and drives the datapath control fields: ALU function, register selects, write enable, bus source and destination. It sits between instruction memory and the register file / ALU datapath.

## Interface
- PC_RESET, 8'h00, program counter value loaded on reset.
- WAIT_MAX, 15, maximum FETCH_WAIT cycles without mem_ack before fault; range 1..255.
- Clk  in  1  single clock; all state updates on rising edge.
- Rst  in  1  synchronous, active-high reset.
- ms_m  in  9  instruction word from memory: op[8:6], ra[5:3], rb[2:0]; sampled only on the acknowledged edge.
- mem_ack  in  1  instruction memory has ms_m valid for the current address.
- band  in  3  ALU flags {neg, carry, zero}; band[0]=zero.
- step  in  1  single-step pulse (used only with SEQ_STEP_EN).
- mem_req  out  1  fetch request.
- Address_Instruction_Bus  out  8  current PC.
- fun  out  3  ALU function.
- b_sel  out  6  source register pair {ra, rb}.
- c_sel  out  3  destination register.
- LE_sel  out  1  register-file write enable.
- outbus  out  2  bus source: 00 ALU, 01 external DataOut_Bus, 10 register to port, 11 idle.
- halted  out  1  sequencer stopped (HALT or fault).
- fault  out  1  fetch timeout occurred.

## Operation
- States: FETCH, FETCH_WAIT, DECODE, EXEC, WB, HALT.
- FETCH:
  - mem_req=1; Address_Instruction_Bus=PC; wait counter cleared.
  - Next state FETCH_WAIT.
- FETCH_WAIT:
  - mem_req held at 1.
  - On mem_ack=1: IR<=ms_m, PC<=PC+1 (mod 256, 8'hFF wraps to 8'h00), go to DECODE.
  - Otherwise increment the wait counter. When the counter reaches WAIT_MAX with no ack: fault<=1, go to HALT.
- DECODE: latch ra/rb/op into control registers; all control outputs idle.
- EXEC, by op:
  - 000 ADD, 001 SUB, 010 AND, 011 OR: fun=op, b_sel={ra,rb}, outbus=00; go to WB.
  - 100 IN: outbus=01, c_sel=ra; go to WB.
  - 101 OUT: b_sel={ra,3'b000}, outbus=10; go to FETCH with no write.
  - 110 JZ: if band[0]=1, PC<={2'b00,ra,rb}; go to FETCH. band is sampled in EXEC only.
  - 111 HALT: go to HALT.
- WB: LE_sel=1 for exactly one cycle; c_sel=ra; fun/b_sel/outbus held from EXEC; go to FETCH.
- HALT: halted=1, mem_req=0, all control outputs idle. HALT is left only by Rst.
- Idle values:
  - fun=000, b_sel=0, c_sel=0, LE_sel=0, outbus=11, mem_req=0.
  - Exceptions: mem_req is 1 in FETCH and FETCH_WAIT.

## Timing
- Reset state:
  - FETCH, PC=PC_RESET, IR=0, wait counter=0.
  - fault=0, halted=0, mem_req=0, all control outputs idle.
  - Rst dominates any state, including FETCH_WAIT with mem_ack high on the same edge: that instruction is discarded.
- Cycles per instruction, with mem_ack returned in the first FETCH_WAIT cycle:
  - ALU/IN: 5 (FETCH, FETCH_WAIT, DECODE, EXEC, WB).
  - OUT/JZ: 4.
  - Each cycle of ack delay adds 1.
- mem_ack while not in FETCH_WAIT is ignored.
- A JZ target equal to PC is legal (tight loop).
- All outputs are registered from state; no combinational path from inputs to outputs.

## Configuration
- SEQ_STEP_EN defined:
  - FETCH holds with mem_req=0 until step=1 is sampled, then proceeds.
  - One instruction runs per step pulse.
  - step is ignored in all other states.
- SEQ_STEP_EN undefined: the step input is unused and FETCH always advances after one cycle.

## Test plan
- Reset, then program ADD r1,r2 (9'b000_001_010) with immediate ack:
  - EXEC cycle: fun=000, b_sel=6'b001_010.
  - Next cycle: LE_sel=1, c_sel=001.
  - PC 00->01.
  - Instruction takes 5 cycles.
- JZ 9'b110_011_110 with band=3'b001 -> PC=8'h1E at the next FETCH. Repeat with band=3'b000 -> PC increments only.
- mem_ack delayed 3 cycles:
  - Instruction takes 8 cycles.
  - mem_req stays high throughout the wait.
  - ms_m changing before the ack is not captured.
- mem_ack never asserted with WAIT_MAX=15 -> fault=1 and halted=1 after 15 wait cycles. Rst clears both, and PC returns to PC_RESET.
- PC=8'hFF fetch -> PC wraps to 8'h00. HALT opcode 9'b111_000_000 -> halted=1, mem_req=0, held until Rst.
- SEQ_STEP_EN build: no fetch without step. Two step pulses -> exactly two instructions complete.

Source files
------------

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute sequencer: owns PC and IR and drives datapath control fields.
// Optional build macro SEQ_STEP_EN: FETCH waits for a step pulse before each instruction.
module instr_sequencer #(
    parameter logic [7:0] PC_RESET = 8'h00,
    parameter int         WAIT_MAX = 15
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [8:0] ms_m,
    input  logic       mem_ack,
    input  logic [2:0] band,
    input  logic       step,
    output logic       mem_req,
    output logic [7:0] Address_Instruction_Bus,
    output logic [2:0] fun,
    output logic [5:0] b_sel,
    output logic [2:0] c_sel,
    output logic       LE_sel,
    output logic [1:0] outbus,
    output logic       halted,
    output logic       fault
);

    // state      | meaning
    // S_FETCH    | present PC, clear wait counter
    // S_FETCH_WAIT | request held until mem_ack or timeout
    // S_DECODE   | IR fields settle, controls idle
    // S_EXEC     | drive ALU/bus controls, resolve OUT/JZ/HALT
    // S_WB       | one-cycle register-file write
    // S_HALT     | stopped until Rst
    typedef enum logic [2:0] {
        S_FETCH, S_FETCH_WAIT, S_DECODE, S_EXEC, S_WB, S_HALT
    } state_t;

    localparam logic [2:0] OP_IN   = 3'b100;
    localparam logic [2:0] OP_OUT  = 3'b101;
    localparam logic [2:0] OP_JZ   = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;
    localparam logic [7:0] LP_WAIT_LAST = 8'(WAIT_MAX - 1);

    state_t     r_state, w_state_nxt;
    logic [7:0] r_pc, w_pc_nxt;
    logic [8:0] r_ir, w_ir_nxt;
    logic [7:0] r_cnt, w_cnt_nxt;
    logic       r_fault, w_fault_nxt;

    logic       r_mem_req, w_mem_req;
    logic [2:0] r_fun, w_fun;
    logic [5:0] r_b_sel, w_b_sel;
    logic [2:0] r_c_sel, w_c_sel;
    logic       r_le_sel, w_le_sel;
    logic [1:0] r_outbus, w_outbus;
    logic       r_halted, w_halted;

    logic [2:0] w_op, w_ra, w_rb;
    logic       w_unused;

    assign w_op = r_ir[8:6];
    assign w_ra = r_ir[5:3];
    assign w_rb = r_ir[2:0];

`ifdef SEQ_STEP_EN
    assign w_unused = ^band[2:1];
`else
    assign w_unused = ^{step, band[2:1]};
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ir_nxt    = r_ir;
        w_cnt_nxt   = r_cnt;
        w_fault_nxt = r_fault;
        case (r_state)
            S_FETCH: begin
                w_cnt_nxt = '0;
`ifdef SEQ_STEP_EN
                if (step) w_state_nxt = S_FETCH_WAIT;
`else
                w_state_nxt = S_FETCH_WAIT;
`endif
            end
            S_FETCH_WAIT: begin
                if (mem_ack) begin
                    w_ir_nxt    = ms_m;
                    w_pc_nxt    = r_pc + 8'd1;
                    w_state_nxt = S_DECODE;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                    if (r_cnt == LP_WAIT_LAST) begin
                        w_fault_nxt = 1'b1;
                        w_state_nxt = S_HALT;
                    end
                end
            end
            S_DECODE: w_state_nxt = S_EXEC;
            S_EXEC: begin
                case (w_op)
                    OP_OUT:  w_state_nxt = S_FETCH;
                    OP_JZ: begin
                        if (band[0]) w_pc_nxt = {2'b00, w_ra, w_rb};
                        w_state_nxt = S_FETCH;
                    end
                    OP_HALT: w_state_nxt = S_HALT;
                    default: w_state_nxt = S_WB;
                endcase
            end
            S_WB:    w_state_nxt = S_FETCH;
            S_HALT:  w_state_nxt = S_HALT;
            default: w_state_nxt = S_FETCH;
        endcase

        // Outputs are decoded from the state being entered so they register cleanly.
        w_mem_req = 1'b0;
        w_fun     = 3'b000;
        w_b_sel   = 6'b000000;
        w_c_sel   = 3'b000;
        w_le_sel  = 1'b0;
        w_outbus  = 2'b11;
        w_halted  = 1'b0;
        case (w_state_nxt)
`ifdef SEQ_STEP_EN
            S_FETCH:      w_mem_req = 1'b0;
`else
            S_FETCH:      w_mem_req = 1'b1;
`endif
            S_FETCH_WAIT: w_mem_req = 1'b1;
            S_HALT:       w_halted  = 1'b1;
            S_EXEC, S_WB: begin
                if (!w_op[2]) begin
                    w_fun    = w_op;
                    w_b_sel  = {w_ra, w_rb};
                    w_outbus = 2'b00;
                end else if (w_op == OP_IN) begin
                    w_outbus = 2'b01;
                    w_c_sel  = w_ra;
                end else if (w_op == OP_OUT) begin
                    w_b_sel  = {w_ra, 3'b000};
                    w_outbus = 2'b10;
                end
                if (w_state_nxt == S_WB) begin
                    w_le_sel = 1'b1;
                    w_c_sel  = w_ra;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state  <= S_FETCH;
            r_pc     <= PC_RESET;
            r_ir     <= '0;
            r_cnt    <= '0;
            r_fault  <= 1'b0;
            r_mem_req <= 1'b0;
            r_fun    <= 3'b000;
            r_b_sel  <= 6'b000000;
            r_c_sel  <= 3'b000;
            r_le_sel <= 1'b0;
            r_outbus <= 2'b11;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_ir     <= w_ir_nxt;
            r_cnt    <= w_cnt_nxt;
            r_fault  <= w_fault_nxt;
            r_mem_req <= w_mem_req;
            r_fun    <= w_fun;
            r_b_sel  <= w_b_sel;
            r_c_sel  <= w_c_sel;
            r_le_sel <= w_le_sel;
            r_outbus <= w_outbus;
            r_halted <= w_halted;
        end
    end

    assign mem_req                 = r_mem_req;
    assign Address_Instruction_Bus = r_pc;
    assign fun                     = r_fun;
    assign b_sel                   = r_b_sel;
    assign c_sel                   = r_c_sel;
    assign LE_sel                  = r_le_sel;
    assign outbus                  = r_outbus;
    assign halted                  = r_halted;
    assign fault                   = r_fault;

endmodule
